// File: rtl/apb_uart_rx.sv
// APB slave UART receiver (8N1): synchronised rx line, start/stop checking,
// byte FIFO behind a stalling DATA register, STATUS register with W1C error flags.
module apb_uart_rx #(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 rx_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  // Input synchroniser and edge detect
  logic       sync1_q, rx_s_q, rx_prev_q, armed_q;
  logic [1:0] vld_q;

  // armed_q only rises once rx_s has shown a real (post-reset) high level, so a
  // line held low through reset release cannot fake a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      vld_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= rx_wire;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      vld_q     <= {vld_q[0], 1'b1};
      armed_q   <= armed_q | (vld_q[1] & rx_s_q);
    end
  end

  // Receive FSM
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d;
  logic          push, frame_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    sh_d      = sh_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && rx_prev_q && !rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          bidx_d = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          sh_d[bidx_q] = rx_s_q;
          cnt_d        = '0;
          if (bidx_q == 3'd7) state_d = ST_STOP;
          else                bidx_d  = bidx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          push      = rx_s_q;
          frame_set = !rx_s_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO, flags and bus decode
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          overrun_q, frame_err_q, rx_irq_q;
  logic          apb_sel, empty, full, pop, push_ok, wr_status;

  assign apb_sel   = S_PSELx & S_PENABLE;
  assign empty     = (level_q == '0);
  assign full      = (level_q == FULL_LVL);
  assign pop       = apb_sel & ~S_PWRITE & (S_PADDR == 2'd0) & ~empty;
  assign push_ok   = push & (~full | pop);
  assign wr_status = apb_sel & S_PWRITE & (S_PADDR == 2'd1);

  always_comb begin
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= sh_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_irq_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      rx_irq_q <= ~empty;
      if (push && full && !pop)            overrun_q   <= 1'b1;
      else if (wr_status && S_PWDATA[2])   overrun_q   <= 1'b0;
      if (frame_set)                       frame_err_q <= 1'b1;
      else if (wr_status && S_PWDATA[3])   frame_err_q <= 1'b0;
    end
  end

  assign rx_irq = rx_irq_q;

  always_comb begin
    S_PREADY = 1'b0;
    S_PRDATA = '0;
    if (apb_sel) begin
      S_PREADY = 1'b1;
      if (!S_PWRITE && S_PADDR == 2'd0) begin
        S_PREADY      = ~empty;
        S_PRDATA[7:0] = mem_q[rd_ptr_q];
      end else if (!S_PWRITE && S_PADDR == 2'd1) begin
        S_PRDATA[0]        = ~empty;
        S_PRDATA[1]        = full;
        S_PRDATA[2]        = overrun_q;
        S_PRDATA[3]        = frame_err_q;
        S_PRDATA[4 +: AW+1] = level_q;
      end
    end
  end

  logic unused_pwdata;
  assign unused_pwdata = ^{S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0]};

endmodule

// File: tb/tb_apb_uart_rx.sv
// Bench for apb_uart_rx: frame table plus directed multi-cycle sequences,
// received bytes checked against a scoreboard queue.
module tb_apb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  S_PADDR = '0;
  logic        S_PWRITE = 1'b0, S_PSELx = 1'b0, S_PENABLE = 1'b0;
  logic [15:0] S_PWDATA = '0;
  logic [15:0] S_PRDATA;
  logic        S_PREADY;
  logic        rx_wire = 1'b1;
  logic        rx_irq;

  apb_uart_rx #(.BUS_WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
    .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .rx_wire(rx_wire), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [15:0] exp_status;
    logic        exp_irq;
  } vec_t;

  vec_t       vecs [6];
  int         vec_cnt = 0;
  int         miss_cnt = 0;
  logic [7:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller must be at a falling clock edge; leaves the line idle-high afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_wire = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_wire = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_wire = stop;
    repeat (CPB) @(negedge clk);
    rx_wire = 1'b1;
  endtask

  task automatic apb_rd(input logic [1:0] a, output logic [15:0] d, output logic ok,
                        output int waited, input int budget);
    d = '0; ok = 1'b0; waited = 0;
    @(negedge clk);
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b0; S_PADDR = a;
    @(negedge clk);
    S_PENABLE = 1'b1;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (S_PREADY) begin
        d = S_PRDATA; ok = 1'b1; waited = i;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
  endtask

  task automatic apb_wr(input logic [1:0] a, input logic [15:0] wd);
    @(negedge clk);
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1; S_PADDR = a; S_PWDATA = wd;
    @(negedge clk);
    S_PENABLE = 1'b1;
    #1;
    chk("wr_ready", S_PREADY, 1);
    @(posedge clk);
    #1;
    S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0; S_PWDATA = '0;
  endtask

  task automatic status_is(input string name, input logic [15:0] exp);
    logic [15:0] d; logic ok; int w;
    apb_rd(2'd1, d, ok, w, 4);
    chk(name, {ok, d}, {1'b1, exp});
  endtask

  task automatic rd_expect(input string name);
    logic [15:0] d; logic ok; int w; logic [7:0] e;
    if (sb.size() == 0) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL %s: got no queued byte, expected one", name);
    end else begin
      e = sb.pop_front();
      apb_rd(2'd0, d, ok, w, 400);
      chk(name, {ok, d}, {1'b1, 8'h00, e});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] d; logic ok; int w; logic [7:0] pat;

    vecs[0] = '{8'h00, 1'b1, 16'h0011, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 16'h0011, 1'b1};
    vecs[2] = '{8'h55, 1'b0, 16'h0008, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 16'h0011, 1'b1};
    vecs[4] = '{8'h6B, 1'b1, 16'h0011, 1'b1};
    vecs[5] = '{8'hC7, 1'b0, 16'h0008, 1'b0};

    // Reset state and idle bus
    repeat (3) @(negedge clk);
    chk("rst_irq", rx_irq, 0);
    chk("idle_ready", S_PREADY, 0);
    chk("idle_rdata", S_PRDATA, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    status_is("rst_status", 16'h0000);

    // Reserved addresses and DATA write
    apb_rd(2'd2, d, ok, w, 4);
    chk("rsv2_rd", {ok, d, 8'(w)}, {1'b1, 16'h0000, 8'd0});
    apb_rd(2'd3, d, ok, w, 4);
    chk("rsv3_rd", {ok, d}, {1'b1, 16'h0000});
    apb_wr(2'd0, 16'h00FF);
    status_is("wr_data_noeffect", 16'h0000);

    // 0xA5 with irq latency around the stop sample
    fork
      begin @(negedge clk); send_frame(8'hA5, 1'b1); end
      begin
        @(negedge clk);
        repeat (150) @(negedge clk);
        chk("a5_irq_early", rx_irq, 0);
        repeat (7) @(negedge clk);
        chk("a5_irq", rx_irq, 1);
      end
    join
    sb.push_back(8'hA5);
    status_is("a5_status", 16'h0011);
    rd_expect("a5_data");
    repeat (2) @(negedge clk);
    chk("a5_irq_clr", rx_irq, 0);

    // Frame table
    foreach (vecs[i]) begin
      @(negedge clk);
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].stop) sb.push_back(vecs[i].data);
      repeat (4) @(negedge clk);
      chk("tbl_irq", rx_irq, vecs[i].exp_irq);
      status_is("tbl_status", vecs[i].exp_status);
      if (vecs[i].stop) rd_expect("tbl_data");
      else begin
        apb_wr(2'd1, 16'h0008);
        status_is("tbl_ferr_clr", 16'h0000);
      end
    end

    // DATA read stalls until a byte arrives
    sb.push_back(8'h3C);
    fork
      begin apb_rd(2'd0, d, ok, w, 3000); end
      begin repeat (2000) @(negedge clk); send_frame(8'h3C, 1'b1); end
    join
    chk("stall_data", {ok, d}, {1'b1, 8'h00, sb.pop_front()});
    chk("stall_wait", (w > 2100), 1);

    // Overrun: 6 back-to-back frames into a 4-deep FIFO
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      send_frame(8'(i), 1'b1);
      if (sb.size() < DEPTH) sb.push_back(8'(i));
    end
    repeat (4) @(negedge clk);
    status_is("ovr_status", 16'h0047);
    apb_wr(2'd1, 16'h0004);
    status_is("ovr_clr", 16'h0043);
    for (int i = 0; i < DEPTH; i++) rd_expect("ovr_data");
    status_is("ovr_drained", 16'h0000);

    // Start-bit glitch
    @(negedge clk);
    rx_wire = 1'b0;
    repeat (4) @(negedge clk);
    rx_wire = 1'b1;
    repeat (200) @(negedge clk);
    status_is("glitch_status", 16'h0000);
    chk("glitch_irq", rx_irq, 0);

    // Full FIFO with a pop on the stop-sample edge
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h11 * 8'(i + 1), 1'b1);
      sb.push_back(8'h11 * 8'(i + 1));
    end
    repeat (4) @(negedge clk);
    fork
      begin @(negedge clk); send_frame(8'h99, 1'b1); end
      begin
        @(negedge clk);
        repeat (152) @(negedge clk);
        apb_rd(2'd0, d, ok, w, 4);
      end
    join
    chk("fullpop_data", {ok, d}, {1'b1, 8'h00, sb.pop_front()});
    sb.push_back(8'h99);
    repeat (2) @(negedge clk);
    status_is("fullpop_status", 16'h0043);
    for (int i = 0; i < DEPTH; i++) rd_expect("fullpop_drain");

    // Reset in the middle of data bit 3 with one byte still buffered
    @(negedge clk);
    send_frame(8'h42, 1'b1);
    repeat (4) @(negedge clk);
    pat = 8'hC3;
    rx_wire = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_wire = pat[i];
      repeat (CPB) @(negedge clk);
    end
    rx_wire = pat[3];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    rx_wire = 1'b0;
    sb.delete();
    #1;
    chk("midrst_irq", rx_irq, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    rx_wire = 1'b1;
    repeat (200) @(negedge clk);
    status_is("midrst_status", 16'h0000);
    chk("midrst_irq2", rx_irq, 0);
    @(negedge clk);
    send_frame(8'h7E, 1'b1);
    sb.push_back(8'h7E);
    repeat (4) @(negedge clk);
    status_is("post_rst_status", 16'h0011);
    rd_expect("post_rst_data");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
